// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line-fill/evict memory responder.
package line_mem_pkg;

    localparam int unsigned LINE_OFFSET_BITS  = 6;
    localparam int unsigned DEFAULT_LINE_BITS = 512;

    // Controller sequencing: write-back first, then read, then pulse and settle.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Byte address to line number; callers truncate to the store's index width.
    function automatic logic [31:0] line_index(input logic [31:0] addr);
        return addr >> LINE_OFFSET_BITS;
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line-granular backing store: one port, synchronous write, registered read.
// The read register holds its value between reads, so it doubles as the
// returned-line output of the controller.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int unsigned LINE_BITS      = DEFAULT_LINE_BITS,
    parameter int unsigned ADDR_LINE_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic                      re,
    input  logic [ADDR_LINE_BITS-1:0] addr,
    input  logic [LINE_BITS-1:0]      wdata,
    output logic [LINE_BITS-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_LINE_BITS;

    logic [LINE_BITS-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read, held until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_mem_ctl.sv
// Memory-side responder for the data cache line-fill/evict interface.
// Captures a miss and/or dirty eviction, commits the write-back, then reads
// the requested line and returns it with a one-cycle response pulse.
// Optional build macro LINE_MEM_STATS_EN adds fill and write-back counters.
module line_mem_ctl
    import line_mem_pkg::*;
#(
    parameter int unsigned LINE_BITS      = DEFAULT_LINE_BITS,
    parameter int unsigned ADDR_LINE_BITS = 10,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cache_miss,
    input  logic [31:0]          i_miss_addr,
    input  logic                 i_evict,
    input  logic [31:0]          i_evict_addr,
    input  logic [LINE_BITS-1:0] i_evict_data,
    output logic [LINE_BITS-1:0] o_memory_line,
    output logic                 o_memory_response,
    output logic                 o_busy
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]          o_fill_count,
    output logic [31:0]          o_wb_count
`endif
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

    state_e                    state;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_LINE_BITS-1:0] miss_idx;
    logic [ADDR_LINE_BITS-1:0] evict_idx;
    logic [LINE_BITS-1:0]      evict_data;
    logic                      miss_flag;
    logic                      evict_flag;

    logic                      mem_we_c;
    logic                      mem_re_c;
    logic [ADDR_LINE_BITS-1:0] mem_addr_c;

    // Array port steering: commit on the last write-back cycle, read on the last read cycle.
    always_comb begin
        mem_we_c   = 1'b0;
        mem_re_c   = 1'b0;
        mem_addr_c = miss_idx;
        if (state == ST_WB) begin
            mem_addr_c = evict_idx;
            mem_we_c   = evict_flag && (cnt == '0);
        end else if (state == ST_RD) begin
            mem_re_c   = (cnt == '0);
        end
    end

    // Request sequencing with registered busy/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            miss_idx          <= '0;
            evict_idx         <= '0;
            evict_data        <= '0;
            miss_flag         <= 1'b0;
            evict_flag        <= 1'b0;
            o_memory_response <= 1'b0;
            o_busy            <= 1'b0;
`ifdef LINE_MEM_STATS_EN
            o_fill_count      <= '0;
            o_wb_count        <= '0;
`endif
        end else begin
            o_memory_response <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cache_miss || i_evict) begin
                        miss_idx   <= ADDR_LINE_BITS'(line_index(i_miss_addr));
                        evict_idx  <= ADDR_LINE_BITS'(line_index(i_evict_addr));
                        evict_data <= i_evict_data;
                        miss_flag  <= i_cache_miss;
                        evict_flag <= i_evict;
                        cnt        <= CNT_RELOAD;
                        state      <= i_evict ? ST_WB : ST_RD;
                        o_busy     <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (cnt == '0) begin
`ifdef LINE_MEM_STATS_EN
                        o_wb_count <= o_wb_count + 32'd1;
`endif
                        if (miss_flag) begin
                            cnt   <= CNT_RELOAD;
                            state <= ST_RD;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        o_memory_response <= 1'b1;
                        state             <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
`ifdef LINE_MEM_STATS_EN
                    o_fill_count <= o_fill_count + 32'd1;
`endif
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Backing store; its read register is the returned line.
    line_mem_array #(
        .LINE_BITS      (LINE_BITS),
        .ADDR_LINE_BITS (ADDR_LINE_BITS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_c),
        .re    (mem_re_c),
        .addr  (mem_addr_c),
        .wdata (evict_data),
        .rdata (o_memory_line)
    );

endmodule

// File: tb/tb_line_mem_ctl.sv
// Scoreboard bench for line_mem_ctl: requests push expected fills, a negedge
// monitor pops and checks data and arrival cycle on every response pulse.
module tb_line_mem_ctl;

    localparam int unsigned LB = 512;
    localparam int unsigned L  = 4;

    typedef struct {
        logic [LB-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_cache_miss;
    logic [31:0]   i_miss_addr;
    logic          i_evict;
    logic [31:0]   i_evict_addr;
    logic [LB-1:0] i_evict_data;
    logic [LB-1:0] o_memory_line;
    logic          o_memory_response;
    logic          o_busy;
`ifdef LINE_MEM_STATS_EN
    logic [31:0]   o_fill_count;
    logic [31:0]   o_wb_count;
`endif

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   pulses;
    int   exp_pulses;
    exp_t sb_q[$];

    logic [LB-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;

    line_mem_ctl #(
        .LINE_BITS      (LB),
        .ADDR_LINE_BITS (10),
        .LATENCY        (L)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cache_miss      (i_cache_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy)
`ifdef LINE_MEM_STATS_EN
        ,
        .o_fill_count      (o_fill_count),
        .o_wb_count        (o_wb_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Response monitor: every pulse must match the oldest expected fill.
    always @(negedge clk) begin
        if (rst && o_memory_response) begin
            pulses = pulses + 1;
            n_checks = n_checks + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_pulse at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (o_memory_line !== e.data) begin
                    n_fail = n_fail + 1;
                    $display("FAIL fill_data got %h want %h", o_memory_line, e.data);
                end
                n_checks = n_checks + 1;
                if (cyc != e.cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL fill_latency got cycle %0d want cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Issue one request, queue its expected fill, and time the busy window.
    task automatic issue(input string name, input logic miss, input logic [31:0] maddr,
                         input logic ev, input logic [31:0] eaddr, input logic [LB-1:0] edata,
                         input logic [LB-1:0] exp_data, input int exp_busy, input bit inject);
        int   cap;
        int   busy_n;
        exp_t e;
        @(negedge clk);
        i_cache_miss = miss;
        i_miss_addr  = maddr;
        i_evict      = ev;
        i_evict_addr = eaddr;
        i_evict_data = edata;
        @(posedge clk);
        #1;
        cap = cyc;
        i_cache_miss = 1'b0;
        i_evict      = 1'b0;
        if (miss) begin
            e.data = exp_data;
            e.cyc  = cap + (ev ? 2 * L : L);
            sb_q.push_back(e);
            exp_pulses = exp_pulses + 1;
        end
        busy_n = 0;
        while (o_busy && busy_n < 100) begin
            busy_n = busy_n + 1;
            if (inject && busy_n == 2) begin
                i_cache_miss = 1'b1;
                i_miss_addr  = 32'h0000_0400;
            end else if (inject && busy_n == 3) begin
                i_cache_miss = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk_int({name, "_busy_cycles"}, busy_n, exp_busy);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; pulses = 0; exp_pulses = 0;
        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'hB0B0_0002}};
        pat_c = {16{32'hC3C3_0003}};
        pat_d = {16{32'hD00D_0004}};
        pat_e = {16{32'hEEEE_0005}};
        pat_f = {16{32'hF1F1_0006}};
        rst = 1'b0;
        i_cache_miss = 1'b0; i_miss_addr = '0;
        i_evict = 1'b0; i_evict_addr = '0; i_evict_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_line("reset_line", o_memory_line, '0);
        chk_int("reset_busy", int'(o_busy), 0);
        chk_int("reset_resp", int'(o_memory_response), 0);
        @(negedge clk);
        rst = 1'b1;

        // Preload line 5, then clean miss to it.
        issue("preload_a", 1'b0, 32'h0, 1'b1, 32'h0000_0140, pat_a, '0, L + 1, 1'b0);
        issue("clean_miss", 1'b1, 32'h0000_0140, 1'b0, 32'h0, '0, pat_a, L + 2, 1'b0);
        chk_line("line_hold", o_memory_line, pat_a);

        // Dirty miss, then read back the evicted line.
        issue("dirty_miss", 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0400, pat_b, pat_a, 2 * L + 2, 1'b0);
        issue("read_evicted", 1'b1, 32'h0000_0400, 1'b0, 32'h0, '0, pat_b, L + 2, 1'b0);

        // Same-line evict and miss returns the fresh data.
        issue("same_line", 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0140, pat_c, pat_c, 2 * L + 2, 1'b0);

        // Evict only, then read it back.
        issue("evict_only", 1'b0, 32'h0, 1'b1, 32'h0000_0080, pat_d, '0, L + 1, 1'b0);
        issue("read_evict_only", 1'b1, 32'h0000_0080, 1'b0, 32'h0, '0, pat_d, L + 2, 1'b0);

        // Address wrap with a second miss injected during RD.
        issue("wrap_ignore", 1'b1, 32'h0001_0140, 1'b0, 32'h0, '0, pat_c, L + 2, 1'b1);

        // Reset while in the write-back phase.
        @(negedge clk);
        i_cache_miss = 1'b1; i_miss_addr = 32'h0000_0080;
        i_evict = 1'b1; i_evict_addr = 32'h0000_0080; i_evict_data = pat_e;
        @(posedge clk);
        #1;
        i_cache_miss = 1'b0; i_evict = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_int("mid_reset_busy", int'(o_busy), 0);
        chk_int("mid_reset_resp", int'(o_memory_response), 0);
        chk_line("mid_reset_line", o_memory_line, '0);
        @(negedge clk);
        rst = 1'b1;
`ifdef LINE_MEM_STATS_EN
        chk_int("stats_reset_fill", int'(o_fill_count), 0);
        chk_int("stats_reset_wb", int'(o_wb_count), 0);
`endif
        issue("after_reset_read", 1'b1, 32'h0000_0080, 1'b0, 32'h0, '0, pat_d, L + 2, 1'b0);
        issue("dirty_after_reset", 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0400, pat_f, pat_c, 2 * L + 2, 1'b0);
`ifdef LINE_MEM_STATS_EN
        chk_int("stats_fill", int'(o_fill_count), 2);
        chk_int("stats_wb", int'(o_wb_count), 1);
`endif
        issue("read_f", 1'b1, 32'h0000_0400, 1'b0, 32'h0, '0, pat_f, L + 2, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk_int("pulse_count", pulses, exp_pulses);
        chk_int("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
